tank_bullet: RTL



---
 rtl/tank_pkg.sv | 41 ++++
 rtl/key_edge_detect.sv | 44 ++++
 rtl/tank_bullet.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// ---------------------------------------------------------------------------
// tank_pkg
// Shared types and constants for the tank game projectile logic.
//   dir_t          : tank / bullet facing direction encoding
//   bullet_state_t : projectile engine state
//   KEY_*          : keyboard scancodes used by the player controls
//   SCREEN_*       : visible pixel bounds (inclusive)
//   ext11()        : zero-extend a 10-bit pixel value into 11-bit math
// ---------------------------------------------------------------------------
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } bullet_state_t;

    localparam logic [7:0] KEY_SPACE = 8'd44;
    localparam logic [7:0] KEY_ENTER = 8'd40;
    localparam logic [7:0] KEY_RIGHT = 8'd79;
    localparam logic [7:0] KEY_LEFT  = 8'd80;
    localparam logic [7:0] KEY_DOWN  = 8'd81;
    localparam logic [7:0] KEY_UP    = 8'd82;

    localparam logic [9:0] SCREEN_X_MIN = 10'd1;
    localparam logic [9:0] SCREEN_X_MAX = 10'd639;
    localparam logic [9:0] SCREEN_Y_MIN = 10'd1;
    localparam logic [9:0] SCREEN_Y_MAX = 10'd479;

    function automatic logic [10:0] ext11(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// ---------------------------------------------------------------------------
// key_edge_detect
// Turns a level "fire key is down" into a single-frame press strobe, so a
// held key never auto-fires.
//   clk       in  frame clock, rising edge
//   rst       in  asynchronous active-high reset
//   keycode   in  current player keycode
//   fire_edge out high on the first frame the fire key is seen
// ---------------------------------------------------------------------------
module key_edge_detect
    import tank_pkg::*;
#(
    parameter logic [7:0] FIRE_KEY = KEY_SPACE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] keycode,
    output logic       fire_edge
);

    logic fire_now;
    logic fire_prev_d;
    logic fire_prev_q;

    assign fire_now = (keycode == FIRE_KEY);

    // Tracked in every engine state, so a key held through COOLDOWN stays
    // "old" and cannot relaunch on its own.
    always_comb begin
        fire_prev_d = fire_now;
    end

    // NOTE: non-blocking in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_prev_q <= 1'b0;
        end else begin
            fire_prev_q <= fire_prev_d;
        end
    end

    assign fire_edge = fire_now && !fire_prev_q;

endmodule

// File: rtl/tank_bullet.sv
// ---------------------------------------------------------------------------
// tank_bullet
// Per-player projectile engine: launches one bullet on a fire-key press in
// the tank's facing direction, advances it once per frame, retires it on a
// hit, screen edge or range limit, then waits out a cooldown.
//   frame_clk     in  frame-rate clock (vsync), rising edge
//   Reset         in  asynchronous active-high reset
//   keycode       in  current player keycode
//   tank_x/y/s    in  tank centre and half-size
//   tank_dir      in  tank facing (dir_t encoding)
//   barrier_hit   in  bullet box overlaps a barrier (external, combinational)
//   target_hit    in  bullet box overlaps the opposing tank
//   bullet_x/y    out bullet centre
//   bullet_s      out bullet half-size (constant)
//   bullet_active out bullet in flight, draw it
//   hit_pulse     out one-frame score strobe
// ---------------------------------------------------------------------------
module tank_bullet
    import tank_pkg::*;
#(
    parameter logic [7:0] FIRE_KEY        = KEY_SPACE,
    parameter logic [9:0] BULLET_SIZE     = 10'd2,
    parameter logic [9:0] BULLET_STEP     = 10'd4,
    parameter logic [7:0] MAX_FRAMES      = 8'd120,
    parameter logic [7:0] COOLDOWN_FRAMES = 8'd30,
    parameter logic [9:0] X_MIN           = SCREEN_X_MIN,
    parameter logic [9:0] X_MAX           = SCREEN_X_MAX,
    parameter logic [9:0] Y_MIN           = SCREEN_Y_MIN,
    parameter logic [9:0] Y_MAX           = SCREEN_Y_MAX
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [9:0] tank_x,
    input  logic [9:0] tank_y,
    input  logic [9:0] tank_s,
    input  logic [1:0] tank_dir,
    input  logic       barrier_hit,
    input  logic       target_hit,
    output logic [9:0] bullet_x,
    output logic [9:0] bullet_y,
    output logic [9:0] bullet_s,
    output logic       bullet_active,
    output logic       hit_pulse
);

    // Legal range for the bullet centre so its whole box stays on screen.
    // Comparing the centre against pre-shrunk limits (instead of adding the
    // size to the centre) keeps every comparison free of wrap-around.
    localparam logic [10:0] CX_LO = ext11(X_MIN) + ext11(BULLET_SIZE);
    localparam logic [10:0] CX_HI = ext11(X_MAX) - ext11(BULLET_SIZE);
    localparam logic [10:0] CY_LO = ext11(Y_MIN) + ext11(BULLET_SIZE);
    localparam logic [10:0] CY_HI = ext11(Y_MAX) - ext11(BULLET_SIZE);

    // Limits one step further in, used to decide whether the next move fits.
    localparam logic [10:0] STEP_X_LO = CX_LO + ext11(BULLET_STEP);
    localparam logic [10:0] STEP_X_HI = CX_HI - ext11(BULLET_STEP);
    localparam logic [10:0] STEP_Y_LO = CY_LO + ext11(BULLET_STEP);
    localparam logic [10:0] STEP_Y_HI = CY_HI - ext11(BULLET_STEP);

    bullet_state_t state_q, state_d;
    dir_t          dir_q, dir_d;
    logic [9:0]    bullet_x_q, bullet_x_d;
    logic [9:0]    bullet_y_q, bullet_y_d;
    logic [7:0]    range_q, range_d;
    logic [7:0]    cool_q, cool_d;
    logic          active_q, active_d;
    logic          hit_q, hit_d;

    logic          fire_edge;
    logic [10:0]   spawn_off;
    logic [10:0]   spawn_x;
    logic [10:0]   spawn_y;
    logic          spawn_ok;
    logic          step_blocked;
    logic [10:0]   cur_x;
    logic [10:0]   cur_y;

    key_edge_detect #(
        .FIRE_KEY (FIRE_KEY)
    ) u_key_edge (
        .clk       (frame_clk),
        .rst       (Reset),
        .keycode   (keycode),
        .fire_edge (fire_edge)
    );

    // Spawn point just outside the tank's leading face. A left/up launch
    // from too close to the edge wraps to a huge 11-bit value and a right/
    // down launch with an oversized tank wraps to a tiny one; both land
    // outside [LO, HI] and are rejected.
    always_comb begin
        spawn_off = ext11(tank_s) + ext11(BULLET_SIZE);
        spawn_x   = ext11(tank_x);
        spawn_y   = ext11(tank_y);
        unique case (dir_t'(tank_dir))
            DIR_LEFT:  spawn_x = ext11(tank_x) - spawn_off;
            DIR_RIGHT: spawn_x = ext11(tank_x) + spawn_off;
            DIR_DOWN:  spawn_y = ext11(tank_y) + spawn_off;
            DIR_UP:    spawn_y = ext11(tank_y) - spawn_off;
        endcase
        spawn_ok = (spawn_x >= CX_LO) && (spawn_x <= CX_HI) &&
                   (spawn_y >= CY_LO) && (spawn_y <= CY_HI);
    end

    // Would one more step along the latched direction push the box off screen?
    always_comb begin
        cur_x = ext11(bullet_x_q);
        cur_y = ext11(bullet_y_q);
        unique case (dir_q)
            DIR_LEFT:  step_blocked = (cur_x < STEP_X_LO);
            DIR_RIGHT: step_blocked = (cur_x > STEP_X_HI);
            DIR_DOWN:  step_blocked = (cur_y > STEP_Y_HI);
            DIR_UP:    step_blocked = (cur_y < STEP_Y_LO);
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d    = state_q;
        dir_d      = dir_q;
        bullet_x_d = bullet_x_q;
        bullet_y_d = bullet_y_q;
        range_d    = range_q;
        cool_d     = cool_q;
        active_d   = active_q;
        hit_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fire_edge && spawn_ok) begin
                    state_d    = FLYING;
                    bullet_x_d = spawn_x[9:0];
                    bullet_y_d = spawn_y[9:0];
                    dir_d      = dir_t'(tank_dir);
                    range_d    = 8'd0;
                    active_d   = 1'b1;
                end
            end

            FLYING: begin
                if (target_hit || barrier_hit || step_blocked ||
                    (range_q == MAX_FRAMES - 8'd1)) begin
                    // Position is left as-is on retirement.
                    state_d  = COOLDOWN;
                    active_d = 1'b0;
                    cool_d   = 8'd0;
                    hit_d    = target_hit;
                end else begin
                    range_d = range_q + 8'd1;
                    unique case (dir_q)
                        DIR_LEFT:  bullet_x_d = bullet_x_q - BULLET_STEP;
                        DIR_RIGHT: bullet_x_d = bullet_x_q + BULLET_STEP;
                        DIR_DOWN:  bullet_y_d = bullet_y_q + BULLET_STEP;
                        DIR_UP:    bullet_y_d = bullet_y_q - BULLET_STEP;
                    endcase
                end
            end

            COOLDOWN: begin
                if (cool_q == COOLDOWN_FRAMES - 8'd1) begin
                    state_d = IDLE;
                end else begin
                    cool_d = cool_q + 8'd1;
                end
            end

            default: begin
                state_d  = IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            dir_q      <= DIR_LEFT;
            bullet_x_q <= 10'd0;
            bullet_y_q <= 10'd0;
            range_q    <= 8'd0;
            cool_q     <= 8'd0;
            active_q   <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            bullet_x_q <= bullet_x_d;
            bullet_y_q <= bullet_y_d;
            range_q    <= range_d;
            cool_q     <= cool_d;
            active_q   <= active_d;
            hit_q      <= hit_d;
        end
    end

    assign bullet_x      = bullet_x_q;
    assign bullet_y      = bullet_y_q;
    assign bullet_s      = BULLET_SIZE;
    assign bullet_active = active_q;
    assign hit_pulse     = hit_q;

endmodule
